// File: rtl/morse_key_timer.sv
// Morse key front end: synchronizes and debounces the key, times presses and gaps,
// and emits registered symbol / letter / word pulses for the decoder back end.
module morse_key_timer #(
    parameter int CNT_W          = 8,
    parameter int DEBOUNCE_TICKS = 2,
    parameter int DASH_TICKS     = 25,
    parameter int LETTER_GAP     = 50,
    parameter int WORD_GAP       = 150,
    parameter int MAX_SYM        = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_en,
    input  logic       key_raw,
    output logic       key_level,
    output logic       sym_valid,
    output logic       sym_dash,
    output logic [2:0] sym_count,
    output logic       letter_done,
    output logic       letter_err,
    output logic       word_done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRESS = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_WGAP  = 2'd3;

    localparam logic [CNT_W-1:0] DB_C   = CNT_W'(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0] DASH_C = CNT_W'(DASH_TICKS);
    localparam logic [CNT_W-1:0] LG_C   = CNT_W'(LETTER_GAP);
    localparam logic [CNT_W-1:0] WG_C   = CNT_W'(WORD_GAP);
    localparam logic [2:0]       MAX_C  = 3'(MAX_SYM);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    logic             key_meta_q, key_s_q;
    logic             key_level_q, key_level_d;
    logic             key_prev_q;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] dur_q, dur_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [2:0]       sym_count_q, sym_count_d;
    logic             err_q, err_d;
    logic             sym_valid_q, sym_valid_d;
    logic             sym_dash_q, sym_dash_d;
    logic             letter_done_q, letter_done_d;
    logic             letter_err_q, letter_err_d;
    logic             word_done_q, word_done_d;
    logic             key_rise, key_fall;
    logic [2:0]       cnt_base;
    logic             err_base;

    assign key_rise = key_level_q & ~key_prev_q;
    assign key_fall = ~key_level_q & key_prev_q;

    // Debounce: a new level must persist for DEBOUNCE_TICKS ticks before it is accepted.
    always_comb begin
        db_cnt_d    = db_cnt_q;
        key_level_d = key_level_q;
        if (key_s_q == key_level_q) begin
            db_cnt_d = '0;
        end else if (tick_en) begin
            if (sat_inc(db_cnt_q) >= DB_C) begin
                key_level_d = ~key_level_q;
                db_cnt_d    = '0;
            end else begin
                db_cnt_d = sat_inc(db_cnt_q);
            end
        end
    end

    // The letter count is cleared one clk after letter_done, so the count stays
    // visible alongside the pulse; a press landing right then starts from zero.
    always_comb begin
        cnt_base      = letter_done_q ? 3'd0 : sym_count_q;
        err_base      = letter_done_q ? 1'b0 : err_q;
        state_d       = state_q;
        dur_d         = dur_q;
        gap_d         = gap_q;
        sym_count_d   = cnt_base;
        err_d         = err_base;
        sym_valid_d   = 1'b0;
        sym_dash_d    = sym_dash_q;
        letter_done_d = 1'b0;
        letter_err_d  = 1'b0;
        word_done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (key_rise) begin
                    state_d = ST_PRESS;
                    dur_d   = '0;
                end
            end
            ST_PRESS: begin
                if (key_fall) begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                    if (cnt_base < MAX_C) begin
                        sym_valid_d = 1'b1;
                        sym_dash_d  = (dur_q >= DASH_C);
                        sym_count_d = cnt_base + 3'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (tick_en) begin
                    dur_d = sat_inc(dur_q);
                end
            end
            ST_GAP: begin
                if (tick_en) gap_d = sat_inc(gap_q);
                if (gap_q == LG_C) begin
                    letter_done_d = 1'b1;
                    letter_err_d  = err_base;
                    state_d       = ST_WGAP;
                end
                if (key_rise) begin
                    state_d = ST_PRESS;
                    dur_d   = '0;
                end
            end
            ST_WGAP: begin
                if (tick_en) gap_d = sat_inc(gap_q);
                if (gap_q == WG_C) begin
                    word_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end
                if (key_rise) begin
                    state_d = ST_PRESS;
                    dur_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_meta_q    <= 1'b0;
            key_s_q       <= 1'b0;
            key_level_q   <= 1'b0;
            key_prev_q    <= 1'b0;
            db_cnt_q      <= '0;
            state_q       <= ST_IDLE;
            dur_q         <= '0;
            gap_q         <= '0;
            sym_count_q   <= 3'd0;
            err_q         <= 1'b0;
            sym_valid_q   <= 1'b0;
            sym_dash_q    <= 1'b0;
            letter_done_q <= 1'b0;
            letter_err_q  <= 1'b0;
            word_done_q   <= 1'b0;
        end else begin
            key_meta_q    <= key_raw;
            key_s_q       <= key_meta_q;
            key_level_q   <= key_level_d;
            key_prev_q    <= key_level_q;
            db_cnt_q      <= db_cnt_d;
            state_q       <= state_d;
            dur_q         <= dur_d;
            gap_q         <= gap_d;
            sym_count_q   <= sym_count_d;
            err_q         <= err_d;
            sym_valid_q   <= sym_valid_d;
            sym_dash_q    <= sym_dash_d;
            letter_done_q <= letter_done_d;
            letter_err_q  <= letter_err_d;
            word_done_q   <= word_done_d;
        end
    end

    assign key_level   = key_level_q;
    assign sym_valid   = sym_valid_q;
    assign sym_dash    = sym_dash_q;
    assign sym_count   = sym_count_q;
    assign letter_done = letter_done_q;
    assign letter_err  = letter_err_q;
    assign word_done   = word_done_q;

endmodule
